// File: rtl/playback_scheduler_pkg.sv
// playback_scheduler_pkg
// Shared types and constants for the buzzer playback scheduler:
//   state_e       - scheduler phases (IDLE, NOTE, GAP, PAUSED)
//   REST          - note code meaning silence
//   END_DURATION  - ROM duration value that marks the end of a song
//   GAP_CYCLES_DEFAULT - default silent cycles after each note
//   song_step()   - wrapping song index increment/decrement
package playback_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_NOTE   = 2'd1,
    ST_GAP    = 2'd2,
    ST_PAUSED = 2'd3
  } state_e;

  localparam int          TIMER_W            = 16;
  localparam logic [3:0]  REST               = 4'd0;
  localparam logic [15:0] END_DURATION       = 16'd0;
  localparam int          GAP_CYCLES_DEFAULT = 500;

  // Step the song index by one in either direction, wrapping 0 <-> num_songs-1.
  function automatic logic [3:0] song_step(input logic [3:0] song,
                                           input logic       up,
                                           input int         num_songs);
    logic [3:0] last;
    last = 4'(num_songs - 1);
    if (up) return (song == last) ? 4'd0 : song + 4'd1;
    else    return (song == 4'd0) ? last : song - 4'd1;
  endfunction

endpackage

// File: rtl/playback_scheduler_if.sv
// playback_scheduler_if
// Bundles the command inputs, live key, song ROM pair and buzzer/status
// outputs of the playback scheduler.
//   master: front end / ROM / buzzer side (drives commands and ROM data)
//   slave : the scheduler (drives ROM address, note_out, playing, paused)
interface playback_scheduler_if;
  logic        cmd_play;
  logic        cmd_stop;
  logic        cmd_next;
  logic        cmd_prev;
  logic        repeat_en;
  logic [3:0]  key_note;
  logic [3:0]  rom_note;
  logic [15:0] rom_duration;
  logic [3:0]  rom_song;
  logic [4:0]  rom_addr;
  logic [3:0]  note_out;
  logic        playing;
  logic        paused;

  modport master (
    output cmd_play, cmd_stop, cmd_next, cmd_prev, repeat_en, key_note,
    output rom_note, rom_duration,
    input  rom_song, rom_addr, note_out, playing, paused
  );

  modport slave (
    input  cmd_play, cmd_stop, cmd_next, cmd_prev, repeat_en, key_note,
    input  rom_note, rom_duration,
    output rom_song, rom_addr, note_out, playing, paused
  );
endinterface

// File: rtl/playback_scheduler_note_timer.sv
// note_timer
// 16-bit up counter shared by the NOTE and GAP phases.
//   clk, reset : clock, synchronous active-high reset
//   clr        : load zero (has priority over en)
//   en         : count up by one
//   limit      : run-time terminal value
//   tc         : high while the count equals limit
module note_timer
  import playback_scheduler_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  input  logic [TIMER_W-1:0] limit,
  output logic               tc
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + TIMER_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign tc = (count_q == limit);

endmodule

// File: rtl/playback_scheduler.sv
// playback_scheduler
// Walks the song ROM entry by entry, timing each note and the silent gap
// after it, handles play/pause/stop/next/prev, and arbitrates the buzzer
// note between live keys and autoplay.
//   clk, reset : clock, synchronous active-high reset
//   bus        : playback_scheduler_if.slave (commands, key, ROM, outputs)
module playback_scheduler
  import playback_scheduler_pkg::*;
#(
  parameter int NUM_SONGS  = 3,
  parameter int SONG_LEN   = 32,
  parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  playback_scheduler_if.slave  bus
);

  localparam logic [15:0] GAP_LIMIT = 16'(GAP_CYCLES - 1);
  localparam logic [4:0]  LAST_ADDR = 5'(SONG_LEN - 1);

  state_e     state_q, state_d;
  state_e     saved_q, saved_d;
  logic [3:0] song_q, song_d;
  logic [4:0] addr_q, addr_d;
  logic [3:0] note_out_q, note_out_d;
  logic       playing_q, playing_d;
  logic       paused_q, paused_d;

  logic        t_clr, t_en, t_tc;
  logic [15:0] t_limit;

  state_e     adv_state;
  logic [4:0] adv_addr;
  logic       adv_clr, adv_en, end_song;

  logic song_cmd, play_cmd;

  // next and prev together cancel; a song command swallows a same-cycle play.
  assign song_cmd = bus.cmd_next ^ bus.cmd_prev;
  assign play_cmd = bus.cmd_play & ~bus.cmd_next & ~bus.cmd_prev;

  assign t_limit = (state_q == ST_GAP) ? GAP_LIMIT : bus.rom_duration - 16'd1;

  note_timer u_note_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (t_clr),
    .en    (t_en),
    .limit (t_limit),
    .tc    (t_tc)
  );

  // Where autoplay goes from NOTE/GAP this cycle, ignoring commands.
  always_comb begin
    adv_state = state_q;
    adv_addr  = addr_q;
    adv_clr   = 1'b0;
    adv_en    = 1'b0;
    end_song  = 1'b0;
    case (state_q)
      ST_NOTE: begin
        if (bus.rom_duration == END_DURATION) end_song = 1'b1;
        else if (t_tc) begin
          adv_state = ST_GAP;
          adv_clr   = 1'b1;
        end else adv_en = 1'b1;
      end
      ST_GAP: begin
        if (t_tc) begin
          if (addr_q == LAST_ADDR) end_song = 1'b1;
          else begin
            adv_addr  = addr_q + 5'd1;
            adv_state = ST_NOTE;
            adv_clr   = 1'b1;
          end
        end else adv_en = 1'b1;
      end
      default: ;
    endcase
    if (end_song) begin
      adv_addr  = '0;
      adv_clr   = 1'b1;
      adv_state = bus.repeat_en ? ST_NOTE : ST_IDLE;
    end
  end

  // Next-state logic: stop > next/prev > play > autoplay.
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    song_d  = song_q;
    addr_d  = addr_q;
    t_clr   = 1'b0;
    t_en    = 1'b0;
    if (bus.cmd_stop) begin
      state_d = ST_IDLE;
      saved_d = ST_NOTE;
      addr_d  = '0;
      t_clr   = 1'b1;
    end else if (song_cmd) begin
      song_d = song_step(song_q, bus.cmd_next, NUM_SONGS);
      case (state_q)
        ST_NOTE, ST_GAP: begin
          state_d = ST_NOTE;
          addr_d  = '0;
          t_clr   = 1'b1;
        end
        ST_PAUSED: begin
          saved_d = ST_NOTE;
          addr_d  = '0;
          t_clr   = 1'b1;
        end
        default: ;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: if (play_cmd) begin
          state_d = ST_NOTE;
          t_clr   = 1'b1;
        end
        ST_NOTE, ST_GAP: begin
          state_d = adv_state;
          addr_d  = adv_addr;
          t_clr   = adv_clr;
          t_en    = adv_en;
          // The cycle in which pause is sampled still counts as played
          // time, so a note keeps its exact length across pause/resume.
          if (play_cmd && adv_state != ST_IDLE) begin
            saved_d = adv_state;
            state_d = ST_PAUSED;
          end
        end
        ST_PAUSED: if (play_cmd) state_d = saved_q;
        default: ;
      endcase
    end
  end

  // Output logic: live key wins; the end marker itself is never sounded.
  always_comb begin
    note_out_d = REST;
    if (bus.key_note != REST) note_out_d = bus.key_note;
    else if (state_q == ST_NOTE && bus.rom_duration != END_DURATION)
      note_out_d = bus.rom_note;
    playing_d = (state_d == ST_NOTE) || (state_d == ST_GAP);
    paused_d  = (state_d == ST_PAUSED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      saved_q    <= ST_NOTE;
      song_q     <= '0;
      addr_q     <= '0;
      note_out_q <= REST;
      playing_q  <= 1'b0;
      paused_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      saved_q    <= saved_d;
      song_q     <= song_d;
      addr_q     <= addr_d;
      note_out_q <= note_out_d;
      playing_q  <= playing_d;
      paused_q   <= paused_d;
    end
  end

  assign bus.rom_song = song_q;
  assign bus.rom_addr = addr_q;
  assign bus.note_out = note_out_q;
  assign bus.playing  = playing_q;
  assign bus.paused   = paused_q;

endmodule

// File: tb/tb_playback_scheduler.sv
// tb_playback_scheduler
// Directed, table-driven bench for playback_scheduler with NUM_SONGS=3,
// SONG_LEN=4, GAP_CYCLES=4 and a small behavioural song ROM.
module tb_playback_scheduler;

  logic clk;
  logic reset;

  playback_scheduler_if bus ();

  playback_scheduler #(
    .NUM_SONGS  (3),
    .SONG_LEN   (4),
    .GAP_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Song ROM: {note, duration}
  //   song0: (1,3) (2,2) (3,5) (4,1)
  //   song1: (5,2) (6,1) (0,0)=end (0,0)
  //   song2: (9,5) (3,4) (11,2) (12,2)
  function automatic logic [19:0] rom_entry(input logic [3:0] s, input logic [4:0] a);
    logic [19:0] e;
    e = 20'd0;
    case ({s, a})
      {4'd0, 5'd0}: e = {4'd1,  16'd3};
      {4'd0, 5'd1}: e = {4'd2,  16'd2};
      {4'd0, 5'd2}: e = {4'd3,  16'd5};
      {4'd0, 5'd3}: e = {4'd4,  16'd1};
      {4'd1, 5'd0}: e = {4'd5,  16'd2};
      {4'd1, 5'd1}: e = {4'd6,  16'd1};
      {4'd2, 5'd0}: e = {4'd9,  16'd5};
      {4'd2, 5'd1}: e = {4'd3,  16'd4};
      {4'd2, 5'd2}: e = {4'd11, 16'd2};
      {4'd2, 5'd3}: e = {4'd12, 16'd2};
      default:      e = 20'd0;
    endcase
    return e;
  endfunction

  always_comb begin
    {bus.rom_note, bus.rom_duration} = rom_entry(bus.rom_song, bus.rom_addr);
  end

  typedef struct {
    logic       rst, play, stop, nxt, prv, rep;
    logic [3:0] key;
    int         n;
    logic [3:0] note;
    logic       ply, pau;
    logic [4:0] addr;
    logic [3:0] song;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input int rst, play, stop, nxt, prv, rep, key, n,
                     input int note, ply, pau, addr, song);
    vec_t v;
    v.rst  = rst[0];  v.play = play[0]; v.stop = stop[0];
    v.nxt  = nxt[0];  v.prv  = prv[0];  v.rep  = rep[0];
    v.key  = key[3:0];
    v.n    = n;
    v.note = note[3:0];
    v.ply  = ply[0];  v.pau  = pau[0];
    v.addr = addr[4:0];
    v.song = song[3:0];
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset        = 1'b0;
    bus.cmd_play = 1'b0;
    bus.cmd_stop = 1'b0;
    bus.cmd_next = 1'b0;
    bus.cmd_prev = 1'b0;
    bus.key_note = 4'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int wait_n, len_n, gap_n;
    reset         = 1'b1;
    bus.cmd_play  = 1'b0;
    bus.cmd_stop  = 1'b0;
    bus.cmd_next  = 1'b0;
    bus.cmd_prev  = 1'b0;
    bus.repeat_en = 1'b0;
    bus.key_note  = 4'd0;

    //  rst pl st nx pv rp key  n   note ply pau addr song
    // Song 0 straight through, repeat off
    add(1, 0, 0, 0, 0, 0, 0,  2,   0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1,   0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0,  1,   0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  3,   1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  3,   0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1,   0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0,  2,   2, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0,  3,   0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1,   0, 1, 0, 2, 0);
    add(0, 0, 0, 0, 0, 0, 0,  5,   3, 1, 0, 2, 0);
    add(0, 0, 0, 0, 0, 0, 0,  3,   0, 1, 0, 2, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1,   0, 1, 0, 3, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1,   4, 1, 0, 3, 0);
    add(0, 0, 0, 0, 0, 0, 0,  3,   0, 1, 0, 3, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1,   0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1,   0, 0, 0, 0, 0);
    // Song 1 has an end marker at addr 2: loop with repeat, then stop without
    add(0, 0, 0, 1, 0, 1, 0,  1,   0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1, 0,  1,   0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0,  2,   5, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0,  3,   0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0,  1,   0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 0,  1,   6, 1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 0,  3,   0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 0,  1,   0, 1, 0, 2, 1);
    add(0, 0, 0, 0, 0, 1, 0,  1,   0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0,  2,   5, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0,  3,   0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0,  1,   0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0,  1,   6, 1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0,  3,   0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0,  1,   0, 1, 0, 2, 1);
    add(0, 0, 0, 0, 0, 0, 0,  1,   0, 0, 0, 0, 1);
    // Song 2: pause/resume mid-note, key override, next/prev wrap, stop+next
    add(0, 0, 0, 1, 0, 0, 0,  1,   0, 0, 0, 0, 2);
    add(0, 1, 0, 0, 0, 0, 0,  1,   0, 1, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0,  1,   9, 1, 0, 0, 2);
    add(0, 1, 0, 0, 0, 0, 0,  1,   9, 0, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 10,   0, 0, 1, 0, 2);
    add(0, 1, 0, 0, 0, 0, 0,  1,   0, 1, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0,  3,   9, 1, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0,  3,   0, 1, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0,  1,   0, 1, 0, 1, 2);
    add(0, 0, 0, 0, 0, 0, 7,  1,   7, 1, 0, 1, 2);
    add(0, 0, 0, 0, 0, 0, 0,  3,   3, 1, 0, 1, 2);
    add(0, 0, 0, 0, 0, 0, 0,  1,   0, 1, 0, 1, 2);
    add(0, 0, 0, 0, 0, 0, 5,  1,   5, 1, 0, 1, 2);
    add(0, 0, 0, 0, 0, 0, 0,  1,   0, 1, 0, 1, 2);
    add(0, 0, 0, 0, 0, 0, 0,  1,   0, 1, 0, 2, 2);
    add(0, 0, 0, 1, 0, 0, 0,  1,  11, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1,   1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,  1,   1, 1, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0,  5,   9, 1, 0, 0, 2);
    add(0, 0, 1, 1, 0, 0, 0,  1,   0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0,  1,   0, 0, 0, 0, 2);
    // prev while paused: song changes, stays paused, resumes at new song start
    add(0, 1, 0, 0, 0, 0, 0,  1,   0, 1, 0, 0, 2);
    add(0, 1, 0, 0, 0, 0, 0,  1,   9, 0, 1, 0, 2);
    add(0, 0, 0, 0, 1, 0, 0,  1,   0, 0, 1, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0,  1,   0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0,  2,   5, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0,  1,   0, 1, 0, 0, 1);
    // reset mid-gap with a key held
    add(1, 0, 0, 0, 0, 0, 6,  1,   0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1,   0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].n; r++) begin
        reset         = tbl[i].rst;
        bus.cmd_play  = tbl[i].play;
        bus.cmd_stop  = tbl[i].stop;
        bus.cmd_next  = tbl[i].nxt;
        bus.cmd_prev  = tbl[i].prv;
        bus.repeat_en = tbl[i].rep;
        bus.key_note  = tbl[i].key;
        tick();
        check("note_out", i, int'(bus.note_out), int'(tbl[i].note));
        check("playing",  i, int'(bus.playing),  int'(tbl[i].ply));
        check("paused",   i, int'(bus.paused),   int'(tbl[i].pau));
        check("rom_addr", i, int'(bus.rom_addr), int'(tbl[i].addr));
        check("rom_song", i, int'(bus.rom_song), int'(tbl[i].song));
      end
    end

    // Measured timing of song 0: latency, first note length, gap length.
    idle_inputs();
    bus.repeat_en = 1'b0;
    bus.cmd_play  = 1'b1;
    tick();
    bus.cmd_play  = 1'b0;
    wait_n = 0;
    while (bus.note_out != 4'd1 && wait_n < 10) begin
      tick();
      wait_n++;
    end
    check("seq_first_note", 0, int'(bus.note_out), 1);
    check("seq_latency", 0, wait_n, 1);
    len_n = 0;
    while (bus.note_out == 4'd1 && len_n < 20) begin
      tick();
      len_n++;
    end
    check("seq_note_len", 0, len_n, 3);
    gap_n = 0;
    while (bus.note_out == 4'd0 && gap_n < 20) begin
      tick();
      gap_n++;
    end
    check("seq_gap_len", 0, gap_n, 4);
    check("seq_second_note", 0, int'(bus.note_out), 2);
    check("seq_second_addr", 0, int'(bus.rom_addr), 1);
    bus.cmd_stop = 1'b1;
    tick();
    bus.cmd_stop = 1'b0;
    check("seq_stop_playing", 0, int'(bus.playing), 0);
    check("seq_stop_addr", 0, int'(bus.rom_addr), 0);
    tick();
    check("seq_stop_note", 0, int'(bus.note_out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/playback_scheduler.md
# playback_scheduler

Sequencing and arbitration controller for the buzzer path. It walks the song ROM address by address, timing each note and the silent gap after it, and handles play, pause, stop, next and previous commands. It also arbitrates the single buzzer note bus between live keyboard input and autoplay. It sits between the button/key front end and the song ROM plus buzzer pair, and replaces ad-hoc index/counter logic inside the playback path.

## Interface
Parameters:
- NUM_SONGS, 3: songs selectable. Song indices are 0..NUM_SONGS-1; must be ≤16.
- SONG_LEN, 32: ROM entries per song. Addresses are 0..SONG_LEN-1; must be ≤32.
- GAP_CYCLES, 500: silent cycles inserted after every note; must be ≥1.

Ports:
- clk  in  1  system clock; the block uses only this clock.
- reset  in  1  synchronous, active-high reset.
- cmd_play  in  1  single-cycle pulse. Starts playback from IDLE, pauses from NOTE/GAP, resumes from PAUSED.
- cmd_stop  in  1  single-cycle pulse. Returns to IDLE with address 0.
- cmd_next  in  1  single-cycle pulse. Selects song+1, wrapping modulo NUM_SONGS.
- cmd_prev  in  1  single-cycle pulse. Selects song-1, wrapping modulo NUM_SONGS.
- repeat_en  in  1  level. When 1, loop the current song at its end.
- key_note  in  4  live keyboard note; 0 means no key pressed.
- rom_note  in  4  combinational ROM note at {rom_song, rom_addr}; 0 means rest.
- rom_duration  in  16  combinational ROM note length in clk cycles. 0 marks end of song.
- rom_song  out  4  song index driven to the ROM.
- rom_addr  out  5  entry address driven to the ROM.
- note_out  out  4  registered note sent to the buzzer.
- playing  out  1  high in NOTE or GAP.
- paused  out  1  high in PAUSED.

## Operation
- States are IDLE, NOTE, GAP and PAUSED. Reset puts the block in IDLE with rom_song=0, rom_addr=0, note_out=0, playing=0, paused=0, and the timer at 0.
- Command priority within one cycle is stop > next/prev > play. If next and prev arrive together, the result is no song change. Lower-priority commands in the same cycle are dropped.
- IDLE:
  - cmd_play goes to NOTE at the current address with the timer cleared.
  - cmd_next/cmd_prev change the song only.
- NOTE:
  - If rom_duration==0 when NOTE is entered or is active, the song has ended (see end-of-song rule).
  - Otherwise the timer counts 0..rom_duration-1, then the block moves to GAP with the timer cleared.
- GAP:
  - The timer counts 0..GAP_CYCLES-1.
  - Then rom_addr increments and the block returns to NOTE.
  - If rom_addr==SONG_LEN-1, this is end of song instead.
- End of song:
  - If repeat_en=1, set rom_addr=0 and go to NOTE.
  - Otherwise set rom_addr=0 and go to IDLE.
- PAUSED:
  - The timer, rom_addr and the saved phase (NOTE or GAP) are frozen.
  - cmd_play resumes the saved phase at the frozen timer value.
  - cmd_stop goes to IDLE.
- cmd_next/cmd_prev in NOTE or GAP: change the song, set rom_addr=0, clear the timer, enter NOTE.
- cmd_next/cmd_prev in PAUSED: change the song, set rom_addr=0, clear the timer, saved phase becomes NOTE, stay in PAUSED.
- cmd_stop in any state: go to IDLE, rom_addr=0, timer=0. rom_song is kept.
- Arbitration of the next note_out value:
  - key_note≠0 always wins; live keys override autoplay.
  - Otherwise, in NOTE the value is rom_note.
  - In all other states the value is 0.
  - The autoplay timer keeps running while a live key overrides.
- Width rules: the timer is 16 bits. Song wrap is 0↔NUM_SONGS-1. rom_addr never exceeds SONG_LEN-1.

## Timing
- rom_song and rom_addr are registered. ROM data is used in the same cycle it is presented.
- note_out has 1-cycle latency from the state and key_note it is computed from.
- A note of duration D is heard for exactly D cycles, followed by exactly GAP_CYCLES cycles of 0. There is no extra cycle between entries.
- A command is acted on at the clock edge where it is sampled high. The state changes at that edge.
- playing and paused are registered and update on the same edge as the state.
- Reset asserted mid-note takes effect at the next edge. note_out is 0 in the cycle after that edge.

## Structure
- Shared package holds:
  - the state enum (IDLE, NOTE, GAP, PAUSED);
  - the REST note code 0;
  - the END_DURATION constant 0;
  - the default value of GAP_CYCLES.
- One sub-module, note_timer: a 16-bit counter with clear, enable and a terminal-count compare against a run-time limit. It is shared between the NOTE and GAP phases.

## Test plan
Bench parameters are GAP_CYCLES=4 and SONG_LEN=4.
- Play with durations {3,2,5,1} and repeat_en=0 → note_out shows n0 for 3 cycles, 0 for 4, n1 for 2, 0 for 4, …; after the last gap the block is in IDLE with rom_addr=0 and playing=0.
- rom_duration=0 at addr 2 with repeat_en=1 → the block returns to addr 0 in NOTE with no gap. With repeat_en=0 it goes to IDLE.
- Pause at cycle 2 of a 5-cycle note, hold 10 cycles, then resume → note_out is 0 while paused; after resume the note sounds for exactly 3 more cycles.
- cmd_next at song 2 with NUM_SONGS=3 → rom_song=0, rom_addr=0, timer cleared. cmd_prev at song 0 → rom_song=2. cmd_stop and cmd_next in the same cycle → IDLE, song unchanged.
- key_note=7 during NOTE with rom_note=3 → note_out=7 the next cycle. After the key is released, note_out=3 and the note end time is unchanged.
- Reset asserted mid-GAP → next cycle shows IDLE, rom_song=0, rom_addr=0, note_out=0, playing=0.
